// File: rtl/skew_mes_pkg.sv
// Shared types for the multi-channel skew measurement controller.
package skew_mes_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHK0     = 3'd1,
        REQ_STB  = 3'd2,
        WAIT_STB = 3'd3,
        DECIDE   = 3'd4,
        STEP     = 3'd5,
        NEXT_CH  = 3'd6,
        DONE     = 3'd7
    } state_t;

    // Search strategy, latched when a measurement starts.
    typedef enum logic {
        MODE_LIN = 1'b0,
        MODE_SAR = 1'b1
    } mode_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_vote_acc.sv
// Strobe accumulator: counts strobes and hits for one code point,
// produces the majority verdict and watches for a missing strobe result.
module skew_vote_acc #(
    parameter int N_SMP = 3,
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic en,
    input  logic valid,
    input  logic cmp,
    output logic last_smp,
    output logic majority,
    output logic timeout
);

    localparam int SMP_W = $clog2(N_SMP + 1);
    localparam logic [SMP_W-1:0] LAST_IDX  = SMP_W'(N_SMP - 1);
    localparam logic [SMP_W-1:0] HALF      = SMP_W'(N_SMP / 2);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((2 ** TMO_W) - 2);

    logic [SMP_W-1:0] smp_cnt;
    logic [SMP_W-1:0] hit_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    // Count accepted strobes and the ones where the comparator fired.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            smp_cnt <= '0;
            hit_cnt <= '0;
        end else if (clear) begin
            smp_cnt <= '0;
            hit_cnt <= '0;
        end else if (en && valid) begin
            smp_cnt <= smp_cnt + SMP_W'(1);
            if (cmp) begin
                hit_cnt <= hit_cnt + SMP_W'(1);
            end
        end
    end

    // Count consecutive waiting cycles without a strobe result.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tmo_cnt <= '0;
        end else if (!en || valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign last_smp = (smp_cnt == LAST_IDX);
    assign majority = (hit_cnt > HALF);
    assign timeout  = en && !valid && (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/multi_skew_mes_ctl.sv
// Multi-channel skew measurement controller: for each slave channel, finds
// the lowest delay code at which the comparator trips, by linear or SAR search.
module multi_skew_mes_ctl
    import skew_mes_pkg::*;
#(
    parameter int CODE_W = 10,
    parameter int N_CH   = 4,
    parameter int N_SMP  = 3,
    parameter int TMO_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic [N_CH-1:0]             s_cmp_out_i,
    input  logic                        run_i,
    input  logic                        mode_i,
    output logic [CODE_W-1:0]           delay_code_o,
    output logic [ch_width(N_CH)-1:0]   ch_sel_o,
    output logic                        stb_req_o,
    input  logic                        stb_valid_i,
    output logic [N_CH*CODE_W-1:0]      res_code_o,
    output logic [N_CH-1:0]             res_err_o,
    output logic                        busy_o,
    output logic                        rdy_o
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int BIT_W = $clog2(CODE_W);
    localparam logic [CODE_W-1:0] ALL_ONES = '1;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [BIT_W-1:0]  MSB_IDX  = BIT_W'(CODE_W - 1);

    state_t              state;
    state_t              next_state;
    mode_t               mode_q;
    logic                chk_q;
    logic [CODE_W-1:0]   base_q;
    logic [BIT_W-1:0]    bit_idx_q;

    logic                acc_en;
    logic                acc_clear;
    logic                last_smp;
    logic                majority;
    logic                timeout;
    logic [CODE_W-1:0]   sar_base_next;
    logic [CODE_W-1:0]   sar_trial;

    assign acc_en    = (state == WAIT_STB) && run_i;
    assign acc_clear = (state == IDLE) || (state == CHK0) ||
                       (state == STEP) || (state == NEXT_CH);

    // A missed trial means the edge lies above it, so its bit stays set.
    assign sar_base_next = majority ? base_q : delay_code_o;
    assign sar_trial     = base_q | (CODE_W'(1) << bit_idx_q);

    skew_vote_acc #(
        .N_SMP (N_SMP),
        .TMO_W (TMO_W)
    ) u_vote (
        .clk      (clk_i),
        .arst     (arst_i),
        .clear    (acc_clear),
        .en       (acc_en),
        .valid    (stb_valid_i),
        .cmp      (s_cmp_out_i[ch_sel_o]),
        .last_smp (last_smp),
        .majority (majority),
        .timeout  (timeout)
    );

    // State register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and status outputs; dropping run_i always aborts.
    always_comb begin
        next_state = state;
        busy_o     = 1'b1;
        rdy_o      = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                next_state = CHK0;
            end
            CHK0:    next_state = REQ_STB;
            REQ_STB: next_state = WAIT_STB;
            WAIT_STB: begin
                if (timeout) begin
                    next_state = NEXT_CH;
                end else if (stb_valid_i) begin
                    next_state = last_smp ? DECIDE : REQ_STB;
                end
            end
            DECIDE: begin
                if (chk_q) begin
                    next_state = majority ? NEXT_CH : STEP;
                end else if (mode_q == MODE_LIN) begin
                    next_state = (majority || (delay_code_o == ALL_ONES)) ? NEXT_CH : STEP;
                end else begin
                    next_state = (bit_idx_q == '0) ? NEXT_CH : STEP;
                end
            end
            STEP:    next_state = REQ_STB;
            NEXT_CH: next_state = (ch_sel_o == LAST_CH) ? DONE : CHK0;
            DONE: begin
                busy_o = 1'b0;
                rdy_o  = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (!run_i) begin
            next_state = IDLE;
        end
    end

    // One-cycle strobe request following each request state.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stb_req_o <= 1'b0;
        end else begin
            stb_req_o <= (state == REQ_STB) && run_i;
        end
    end

    // Search datapath: code under test, SAR bookkeeping and per-channel results.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            delay_code_o <= '0;
            ch_sel_o     <= '0;
            res_code_o   <= '0;
            res_err_o    <= '0;
            mode_q       <= MODE_LIN;
            chk_q        <= 1'b0;
            base_q       <= '0;
            bit_idx_q    <= '0;
        end else if (run_i) begin
            case (state)
                IDLE: begin
                    mode_q       <= mode_t'(mode_i);
                    res_code_o   <= '0;
                    res_err_o    <= '0;
                    ch_sel_o     <= '0;
                    delay_code_o <= '0;
                end
                CHK0: begin
                    delay_code_o <= '0;
                    chk_q        <= 1'b1;
                    base_q       <= '0;
                    bit_idx_q    <= MSB_IDX;
                end
                WAIT_STB: begin
                    if (timeout) begin
                        res_err_o[ch_sel_o] <= 1'b1;
                    end
                end
                DECIDE: begin
                    if (chk_q) begin
                        chk_q <= 1'b0;
                        if (majority) begin
                            res_err_o[ch_sel_o] <= 1'b1;
                            res_code_o[ch_sel_o*CODE_W +: CODE_W] <= '0;
                        end
                    end else if (mode_q == MODE_LIN) begin
                        if (majority) begin
                            res_code_o[ch_sel_o*CODE_W +: CODE_W] <= delay_code_o;
                        end else if (delay_code_o == ALL_ONES) begin
                            res_err_o[ch_sel_o] <= 1'b1;
                            res_code_o[ch_sel_o*CODE_W +: CODE_W] <= ALL_ONES;
                        end
                    end else begin
                        base_q <= sar_base_next;
                        if (bit_idx_q == '0) begin
                            if (sar_base_next == ALL_ONES) begin
                                res_err_o[ch_sel_o] <= 1'b1;
                                res_code_o[ch_sel_o*CODE_W +: CODE_W] <= ALL_ONES;
                            end else begin
                                res_code_o[ch_sel_o*CODE_W +: CODE_W] <= sar_base_next + CODE_W'(1);
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q - BIT_W'(1);
                        end
                    end
                end
                STEP: begin
                    if (mode_q == MODE_LIN) begin
                        delay_code_o <= delay_code_o + CODE_W'(1);
                    end else begin
                        delay_code_o <= sar_trial;
                    end
                end
                NEXT_CH: begin
                    delay_code_o <= '0;
                    if (ch_sel_o != LAST_CH) begin
                        ch_sel_o <= ch_sel_o + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multi_skew_mes_ctl.md
MULTI_SKEW_MES_CTL -- requirements
Module: multi_skew_mes_ctl

Interface
REQ-001 SHALL have parameter CODE_W, default 10, delay-code width (>=2).
REQ-002 SHALL have parameter N_CH, default 4, number of slave comparator channels (>=1).
REQ-003 SHALL have parameter N_SMP, default 3, strobes per code point (odd, >=1).
REQ-004 SHALL have parameter TMO_W, default 8, strobe-timeout counter width; timeout = 2**TMO_W-1 cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1, rising-edge clock; arst_i input 1, asynchronous active-high reset.
REQ-006 SHALL have s_cmp_out_i input N_CH, per-channel slave comparator outputs.
REQ-007 SHALL have run_i input 1, level; high starts and holds a measurement, low aborts.
REQ-008 SHALL have mode_i input 1, 0 = linear sweep, 1 = binary (SAR) search; sampled on leaving IDLE.
REQ-009 SHALL have delay_code_o output CODE_W, delay code under test.
REQ-010 SHALL have ch_sel_o output max(1,$clog2(N_CH)), channel under test.
REQ-011 SHALL have stb_req_o output 1, one-cycle strobe request; stb_valid_i input 1, strobe result valid.
REQ-012 SHALL have res_code_o output N_CH*CODE_W, per-channel result, channel k at bits [k*CODE_W +: CODE_W].
REQ-013 SHALL have res_err_o output N_CH, per-channel error flags; busy_o output 1; rdy_o output 1.

Function
REQ-014 SHALL use states IDLE, CHK0, REQ_STB, WAIT_STB, DECIDE, STEP, NEXT_CH, DONE.
REQ-015 SHALL go to IDLE on the next edge whenever run_i is low, from any state.
REQ-016 SHALL, in IDLE with run_i high, latch mode_i, clear res_code_o/res_err_o, set channel 0, code 0, then enter CHK0.
REQ-017 SHALL register stb_req_o high for exactly one cycle following each REQ_STB cycle.
REQ-018 SHALL sample s_cmp_out_i[ch_sel_o] only in WAIT_STB cycles with stb_valid_i high; hit counter increments on 1.
REQ-019 SHALL repeat REQ_STB/WAIT_STB N_SMP times per code point; point result = hit count > N_SMP/2 (majority).
REQ-020 SHALL, if stb_valid_i stays low TMO_W-timeout cycles in WAIT_STB, set res_err_o[ch] and go to NEXT_CH.
REQ-021 SHALL first measure code 0 (CHK0); majority hit at code 0 -> res_err_o[ch]=1, res_code=0, NEXT_CH.
REQ-022 SHALL, linear mode: no hit -> STEP increments code by 1; hit at code c -> res_code=c; no hit at all-ones -> error, res_code=all-ones.
REQ-023 SHALL, SAR mode: per bit MSB to LSB test trial=base|bit; no hit keeps bit in base; after LSB res_code=base+1; base all-ones -> error, res_code=all-ones.
REQ-024 SHALL in NEXT_CH advance ch_sel_o, reset code/counters to 0 and re-enter CHK0; after channel N_CH-1 enter DONE.
REQ-025 SHALL hold DONE while run_i high; rdy_o=1 only in DONE; busy_o=1 in every state except IDLE and DONE.
REQ-026 SHALL ignore stb_valid_i outside WAIT_STB; a stb_valid_i coincident with run_i falling is discarded.
REQ-027 SHALL keep delay_code_o stable from REQ_STB through the final WAIT_STB of a code point.

Reset
REQ-028 SHALL on arst_i force: state IDLE, delay_code_o 0, ch_sel_o 0, stb_req_o 0, res_code_o 0, res_err_o 0, busy_o 0, rdy_o 0, all counters 0.
REQ-029 SHALL allow reset assertion mid-sweep with no partial result retained.

Structure
REQ-030 SHALL place the state enum and mode enum (MODE_LIN, MODE_SAR) in shared package skew_mes_pkg.
REQ-031 SHALL implement strobe counting, majority vote and timeout in sub-module skew_vote_acc.

Verification (CODE_W=4, N_CH=2, N_SMP=3)
REQ-032 SHALL cover linear, ch0 hits at code>=5, ch1 at code>=9 -> res_code {9,5}, res_err 00, rdy_o=1.
REQ-033 SHALL cover SAR, edge at 11 -> codes tested 0,8,12,10,11, res_code 11, 5 code points x 3 strobes.
REQ-034 SHALL cover ch0 hits at code 0 -> res_err[0]=1, res_code[0]=0; ch1 measured normally.
REQ-035 SHALL cover no hit through code 15 both modes -> res_err=11, res_code=15 each.
REQ-036 SHALL cover votes 1,0,1 at code 5 -> hit; votes 0,1,0 -> miss; stb_valid_i withheld -> timeout error.
REQ-037 SHALL cover run_i low mid-WAIT_STB -> IDLE next edge, stb_req_o 0, busy_o 0; arst_i mid-sweep -> all outputs 0.
